// File: rtl/hynoc_prra_arbiter.sv
// hynoc_prra_arbiter: packet-level round-robin arbiter for one HyNoC output port.
// A registered grant is issued to the next requester after the last served
// port and held until that port ends its packet (release or abort). On
// end-of-packet the next winner is picked on the same edge, so there is no idle cycle.
// Optional watchdog: define HYNOC_PRRA_ARBITER_TIMEOUT_EN to force a release
// after TIMEOUT_CYCLES granted cycles and pulse 'timeout'.
// 'release' is a SystemVerilog keyword, so the end-of-packet input is named pkt_release.
module hynoc_prra_arbiter #(
   parameter int WIDTH          = 4,
   parameter int LOG2_WIDTH     = 2,
   parameter int TIMEOUT_CYCLES = 256
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [WIDTH-1:0]      request,
   input  logic                  pkt_release,
   output logic [WIDTH-1:0]      grant,
   output logic [LOG2_WIDTH-1:0] grant_id,
`ifdef HYNOC_PRRA_ARBITER_TIMEOUT_EN
   output logic                  timeout,
`endif
   output logic                  grant_valid
);

   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] GRANTED = 1'b1;

   logic [0:0]            state;
   logic [LOG2_WIDTH-1:0] last;
   logic                  found;
   logic [LOG2_WIDTH-1:0] cand;
   logic                  wd_fire;
   logic                  end_pkt;
   logic                  do_arb;

   // Round-robin search starting just after 'last'. While a grant is held,
   // last == grant_id, so the releasing port is scanned last: it only wins
   // again when no other port is requesting.
   always_comb begin
      found = 1'b0;
      cand  = '0;
      for (int k = WIDTH - 1; k >= 0; k--) begin
         int idx;
         idx = (int'(last) + k + 1) % WIDTH;
         if (request[idx]) begin
            found = 1'b1;
            cand  = idx[LOG2_WIDTH-1:0];
         end
      end
   end

`ifdef HYNOC_PRRA_ARBITER_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
   logic [CW-1:0] wd_cnt;

   // Watchdog fires on the edge that completes TIMEOUT_CYCLES granted cycles.
   assign wd_fire = grant_valid && !pkt_release && request[grant_id] &&
                    (wd_cnt == CW'(TIMEOUT_CYCLES - 1));

   // Counter clears on every new grant, counts granted cycles, saturates.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_cnt  <= '0;
         timeout <= 1'b0;
      end else begin
         timeout <= wd_fire;
         if (do_arb && found)
            wd_cnt <= '0;
         else if (grant_valid && wd_cnt != CW'(TIMEOUT_CYCLES))
            wd_cnt <= wd_cnt + 1'b1;
      end
   end
`else
   assign wd_fire = 1'b0;
`endif

   // An abort (request dropped without release) ends the packet like a release.
   assign end_pkt = grant_valid && (pkt_release || !request[grant_id] || wd_fire);
   assign do_arb  = (state == IDLE) || end_pkt;

   // Grant FSM: arbitrate when idle or at end-of-packet, otherwise hold.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         last        <= LOG2_WIDTH'(WIDTH - 1);
         grant       <= '0;
         grant_id    <= '0;
         grant_valid <= 1'b0;
      end else if (do_arb) begin
         if (found) begin
            state       <= GRANTED;
            last        <= cand;
            grant       <= WIDTH'(1) << cand;
            grant_id    <= cand;
            grant_valid <= 1'b1;
         end else begin
            state       <= IDLE;
            grant       <= '0;
            grant_id    <= '0;
            grant_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_hynoc_prra_arbiter.sv
// Self-checking bench for hynoc_prra_arbiter (default build, WIDTH=4).
// Reference model: the holder port index (-1 = none) plus the last served port.
module tb_hynoc_prra_arbiter;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] request = '0;
   logic         pkt_release = 1'b0;
   logic [W-1:0] grant;
   logic [1:0]   grant_id;
   logic         grant_valid;
`ifdef HYNOC_PRRA_ARBITER_TIMEOUT_EN
   logic         timeout;
`endif

   int checks = 0;
   int errors = 0;
   int m_holder = -1;
   int m_last = W - 1;

   hynoc_prra_arbiter #(.WIDTH(W), .LOG2_WIDTH(2), .TIMEOUT_CYCLES(256)) dut (
      .clk(clk), .rst(rst), .request(request), .pkt_release(pkt_release),
      .grant(grant), .grant_id(grant_id),
`ifdef HYNOC_PRRA_ARBITER_TIMEOUT_EN
      .timeout(timeout),
`endif
      .grant_valid(grant_valid));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // First requester in the order last+1, last+2, ... (mod W); -1 if none.
   function automatic int rr_pick(input logic [W-1:0] req, input int from);
      for (int k = 1; k <= W; k++)
         if (req[(from + k) % W]) return (from + k) % W;
      return -1;
   endfunction

   function automatic void model_step(input logic [W-1:0] req, input logic rel);
      int p;
      if (m_holder < 0 || rel || !req[m_holder]) begin
         p = rr_pick(req, m_last);
         m_holder = p;
         if (p >= 0) m_last = p;
      end
   endfunction

   task automatic check_model(input string tag);
      int eg;
      eg = (m_holder >= 0) ? (1 << m_holder) : 0;
      chk({tag, ".grant"}, int'(grant), eg);
      chk({tag, ".id"}, int'(grant_id), (m_holder >= 0) ? m_holder : 0);
      chk({tag, ".valid"}, int'(grant_valid), (m_holder >= 0) ? 1 : 0);
   endtask

   // Called at a negedge: drive, let one rising edge pass, compare at the next negedge.
   task automatic cycle(input logic [W-1:0] req, input logic rel, input string tag);
      request = req;
      pkt_release = rel;
      @(posedge clk);
      model_step(req, rel);
      @(negedge clk);
      check_model(tag);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      request = '0;
      pkt_release = 1'b0;
      m_holder = -1;
      m_last = W - 1;
      @(negedge clk);
      @(negedge clk);
      check_model("rst");
      rst = 1'b0;
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // Two requesters: lowest after pointer wins, release hands over with no gap.
      cycle(4'b0110, 1'b0, "t1a");
      chk("t1a.const", int'(grant), 4'b0010);
      cycle(4'b0110, 1'b1, "t1b");
      chk("t1b.const", int'(grant), 4'b0100);
      chk("t1b.noidle", int'(grant_valid), 1);

      // All requesting with a release each packet: rotation and wrap.
      do_reset();
      cycle(4'b1111, 1'b0, "t2.0");
      chk("t2.0.const", int'(grant), 4'b0001);
      cycle(4'b1111, 1'b1, "t2.1");
      chk("t2.1.const", int'(grant), 4'b0010);
      cycle(4'b1111, 1'b1, "t2.2");
      cycle(4'b1111, 1'b1, "t2.3");
      chk("t2.3.const", int'(grant), 4'b1000);
      cycle(4'b1111, 1'b1, "t2.4");
      chk("t2.wrap", int'(grant), 4'b0001);

      // No preemption: grant 2 held while others change, then moves to 3.
      do_reset();
      cycle(4'b0100, 1'b0, "t3a");
      cycle(4'b1011 | 4'b0100, 1'b0, "t3b");
      cycle(4'b1111, 1'b0, "t3c");
      chk("t3.hold", int'(grant), 4'b0100);
      cycle(4'b1111, 1'b1, "t3d");
      chk("t3.next", int'(grant), 4'b1000);

      // Sole requester re-granted back-to-back.
      do_reset();
      cycle(4'b1000, 1'b0, "t4a");
      for (int i = 0; i < 3; i++) begin
         cycle(4'b1000, 1'b1, "t4r");
         chk("t4.valid", int'(grant_valid), 1);
         chk("t4.id", int'(grant_id), 3);
      end

      // Abort: holder drops its request without release.
      cycle(4'b0001, 1'b0, "t5abort");
      chk("t5.const", int'(grant), 4'b0001);
      cycle(4'b0000, 1'b0, "t5idle");
      chk("t5.idle", int'(grant_valid), 0);

      // Asynchronous reset mid-packet, then search restarts at port 0.
      cycle(4'b0100, 1'b0, "t6a");
      chk("t6.pre", int'(grant), 4'b0100);
      #2 rst = 1'b1;
      #1;
      chk("t6.async.grant", int'(grant), 0);
      chk("t6.async.valid", int'(grant_valid), 0);
      chk("t6.async.id", int'(grant_id), 0);
      m_holder = -1;
      m_last = W - 1;
      @(negedge clk);
      rst = 1'b0;
      cycle(4'b0101, 1'b0, "t6b");
      chk("t6.restart", int'(grant), 4'b0001);

      // Randomized traffic against the model, with structural invariants.
      for (int i = 0; i < 3000; i++) begin
         logic [W-1:0] r;
         logic rl;
         r = W'($urandom_range(0, 15));
         rl = ($urandom_range(0, 9) < 3);
         cycle(r, rl, "rnd");
         chk("rnd.onehot", $countones(grant) <= 1 ? 1 : 0, 1);
         chk("rnd.valid_eq", int'(grant != 0), int'(grant_valid));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
